// File: rtl/mult_div_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit with HI/LO, one bit per cycle (shift-add / restoring divide).
// Latency: done WIDTH+3 cycles after start (divide-by-zero: 2); MULDIV_EARLY_EXIT_EN shortens multiplies.
// No backpressure: start is accepted only in IDLE and ignored while busy or done.
module mult_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] oper_A,
    input  logic [WIDTH-1:0] oper_B,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;      // multiplicand or divisor
    logic [WIDTH-1:0]   shf_q, shf_d;      // multiplier or dividend, consumed one bit per iteration
    logic [2*WIDTH-1:0] acc_q, acc_d;      // {upper, lower} = product or {rem, quo}
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sign_res_q, sign_res_d;
    logic               sign_rem_q, sign_rem_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               is_div, is_sgn;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH-1:0]   mul_add;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rem_sh;
    logic [WIDTH:0]     div_rem_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_raw, rem_raw;

    assign is_div = op_q[1];
    assign is_sgn = ~op_q[0];

    // During LOAD, dvs_q/shf_q still hold the raw oper_A/oper_B captured in IDLE.
    assign mag_a = (is_sgn && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
    assign mag_b = (is_sgn && shf_q[WIDTH-1]) ? -shf_q : shf_q;

    assign mul_add     = shf_q[0] ? dvs_q : '0;
    assign mul_sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
    assign div_rem_sh  = {acc_q[2*WIDTH-1:WIDTH], shf_q[WIDTH-1]};
    assign div_ge      = div_rem_sh >= {1'b0, dvs_q};
    assign div_rem_sub = div_ge ? (div_rem_sh - {1'b0, dvs_q}) : div_rem_sh;

    assign prod_fix = sign_res_q ? -acc_q : acc_q;
    assign quo_raw  = acc_q[WIDTH-1:0];
    assign rem_raw  = acc_q[2*WIDTH-1:WIDTH];

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            dvs_q      <= '0;
            shf_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            sign_res_q <= 1'b0;
            sign_rem_q <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            dvs_q      <= dvs_d;
            shf_q      <= shf_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sign_res_q <= sign_res_d;
            sign_rem_q <= sign_rem_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        dvs_d      = dvs_q;
        shf_d      = shf_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sign_res_d = sign_res_q;
        sign_rem_d = sign_rem_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    dvs_d   = oper_A;
                    shf_d   = oper_B;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                sign_res_d = is_sgn & (dvs_q[WIDTH-1] ^ shf_q[WIDTH-1]);
                sign_rem_d = is_sgn & dvs_q[WIDTH-1];
                acc_d      = '0;
                cnt_d      = CW'(WIDTH);
                dz_d       = 1'b0;
                if (is_div) begin
                    dvs_d = mag_b;
                    shf_d = mag_a;
                end else begin
                    dvs_d = mag_a;
                    shf_d = mag_b;
                end
                if (is_div && (shf_q == '0)) begin
                    dz_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                cnt_d = cnt_q - 1'b1;
                if (is_div) begin
                    acc_d = {div_rem_sub[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
                    shf_d = shf_q << 1;
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    shf_d = shf_q >> 1;
                end
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
`ifdef MULDIV_EARLY_EXIT_EN
                // Remaining iterations would only shift right, so do them all at once.
                if (!is_div && (shf_q == '0)) begin
                    acc_d   = acc_q >> cnt_q;
                    cnt_d   = '0;
                    state_d = S_FIX;
                end
`endif
            end
            S_FIX: begin
                if (is_div) begin
                    lo_d = sign_res_q ? -quo_raw : quo_raw;
                    hi_d = sign_rem_q ? -rem_raw : rem_raw;
                end else begin
                    lo_d = prod_fix[WIDTH-1:0];
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy     = (state_q == S_LOAD) || (state_q == S_ITER) || (state_q == S_FIX);
    assign done     = (state_q == S_DONE);
    assign div_zero = (state_q == S_DONE) && dz_q;
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed + random scoreboard bench for mult_div_seq; expected HI/LO come from a 64-bit reference model.
module tb_mult_div_seq;
    localparam int W = 32;

    logic          Clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  oper_A, oper_B;
    logic          busy, done, div_zero;
    logic [W-1:0]  HI, LO;

    mult_div_seq #(.WIDTH(W)) dut (
        .Clk      (Clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .oper_A   (oper_A),
        .oper_B   (oper_B),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .HI       (HI),
        .LO       (LO)
    );

    always #5 Clk = ~Clk;

    int cyc_n = 0;
    always @(posedge Clk) cyc_n <= cyc_n + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] hi_m = '0;
    logic [W-1:0] lo_m = '0;
    int           d1, d2, dtmp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [63:0] prev);
        longint sa, sb_, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        case (o)
            2'b00: p = 64'(sa * sb_);
            2'b01: p = {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == '0) p = prev;
                else begin
                    q = sa / sb_;
                    r = sa % sb_;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == '0) p = prev;
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    function automatic int lat_of(input logic [1:0] o, input logic [W-1:0] b);
        int l;
        l = 35;
        if (o[1] && b == '0) l = 2;
`ifdef MULDIV_EARLY_EXIT_EN
        if (!o[1]) begin
            logic [W-1:0] mb;
            int k;
            mb = (!o[0] && b[W-1]) ? -b : b;
            k = -1;
            for (int i = 0; i < W; i++) if (mb[i]) k = i;
            l = (k < 0) ? 4 : ((k + 5 > 35) ? 35 : k + 5);
        end
`endif
        return l;
    endfunction

    // Called just after a rising edge; returns just after the edge following done.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic hold, output int done_at);
        exp_t e, g;
        logic [63:0] r;
        bit got;
        r     = ref_res(o, a, b, {hi_m, lo_m});
        e.hi  = r[63:32];
        e.lo  = r[31:0];
        e.dz  = o[1] && (b == '0);
        e.cyc = cyc_n + lat_of(o, b);
        hi_m  = e.hi;
        lo_m  = e.lo;
        sb.push_back(e);
        start  = 1'b1;
        op     = o;
        oper_A = a;
        oper_B = b;
        @(posedge Clk);
        #1;
        start  = hold;
        oper_A = $urandom;
        oper_B = $urandom;
        op     = 2'($urandom_range(3, 0));
        got     = 0;
        done_at = -1;
        for (int k = 0; k < 80 && !got; k++) begin
            @(negedge Clk);
            if (done) begin
                got     = 1;
                done_at = cyc_n;
                g       = sb.pop_front();
                chk("done_cycle", 64'(cyc_n), 64'(g.cyc));
                chk("HI", 64'(HI), 64'(g.hi));
                chk("LO", 64'(LO), 64'(g.lo));
                chk("div_zero", 64'(div_zero), 64'(g.dz));
                chk("busy_in_done", 64'(busy), 64'(0));
            end else begin
                chk("busy_while_running", 64'(busy), 64'(1));
            end
        end
        chk("done_seen", 64'(got), 64'(1));
        @(posedge Clk);
        #1;
        chk("done_one_cycle", 64'(done), 64'(0));
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        oper_A = '0;
        oper_B = '0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_dz", 64'(div_zero), 64'(0));
        chk("rst_HI", 64'(HI), 64'(0));
        chk("rst_LO", 64'(LO), 64'(0));
        reset = 1'b0;
        @(posedge Clk);
        #1;

        run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, dtmp);
        chk("mult_neg_HI", 64'(HI), 64'hFFFF_FFFF);
        chk("mult_neg_LO", 64'(LO), 64'hFFFF_FFFE);
        run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, dtmp);
        chk("multu_HI", 64'(HI), 64'h0000_0001);
        chk("multu_LO", 64'(LO), 64'hFFFF_FFFE);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, dtmp);
        chk("div_neg_HI", 64'(HI), 64'hFFFF_FFFF);
        chk("div_neg_LO", 64'(LO), 64'hFFFF_FFFD);
        run_op(2'b11, 32'd7, 32'd2, 1'b0, dtmp);
        run_op(2'b11, 32'd7, 32'd0, 1'b0, dtmp);
        chk("divz_HI_kept", 64'(HI), 64'd1);
        chk("divz_LO_kept", 64'(LO), 64'd3);
        run_op(2'b10, 32'h8000_0000, 32'd0, 1'b0, dtmp);

        // Abort a multiply with reset ten cycles after start.
        d1     = cyc_n;
        start  = 1'b1;
        op     = 2'b00;
        oper_A = 32'd12345;
        oper_B = 32'hFFFF_0001;
        @(posedge Clk);
        #1;
        start = 1'b0;
        while (cyc_n < d1 + 10) begin
            @(posedge Clk);
            #1;
        end
        reset = 1'b1;
        @(posedge Clk);
        #1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_HI", 64'(HI), 64'(0));
        chk("abort_LO", 64'(LO), 64'(0));
        reset = 1'b0;
        hi_m  = '0;
        lo_m  = '0;
        @(posedge Clk);
        #1;
        run_op(2'b00, 32'hFFFF_FFF3, 32'h0000_0005, 1'b0, dtmp);

        // start held high across DONE: next op may only begin from IDLE.
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, d1);
        chk("minint_div_HI", 64'(HI), 64'h0);
        chk("minint_div_LO", 64'(LO), 64'h8000_0000);
        run_op(2'b11, 32'd100, 32'd7, 1'b0, d2);
        chk("b2b_gap", 64'(d2 - d1), 64'(W + 4));

        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, dtmp);
        run_op(2'b10, 32'd6, 32'hFFFF_FFFD, 1'b0, dtmp);
        run_op(2'b00, 32'h1234_5678, 32'd0, 1'b0, dtmp);
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = (i % 2 == 0) ? W'($urandom_range(300, 1)) : $urandom;
            run_op(2'(i % 4), ra, rb, 1'b0, dtmp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_div_seq.md
Name: mult_div_seq

Overview:
Multicycle MULT/MULTU/DIV/DIVU sequencer with its own HI/LO result registers, placed beside the ALU in the multicycle MIPS datapath.
- The main control FSM pulses start with the A/B register contents.
- Control holds in a wait state while busy is high, then resumes on done.
- HI/LO feed the MFHI/MFLO write-back mux inputs.
- Iterates one bit per cycle using shift-add (multiply) and restoring shift-subtract (divide).

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits; iteration count = WIDTH.

Ports:
Clk  in  1  system clock, rising-edge
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
oper_A  in  WIDTH  multiplicand / dividend; sampled with start
oper_B  in  WIDTH  multiplier / divisor; sampled with start
busy  out  1  high in LOAD, ITER, FIX
done  out  1  one-cycle pulse in DONE state
div_zero  out  1  high only during DONE of a DIV/DIVU with oper_B==0
HI  out  WIDTH  product[2W-1:W] or remainder
LO  out  WIDTH  product[W-1:0] or quotient

Behaviour:
- Reset: synchronous, active-high; state IDLE, HI=LO=0, busy=done=div_zero=0, internal counter/accumulators=0.
- Reset has priority over everything and aborts any operation mid-flight; no partial result reaches HI/LO.
- States: IDLE, LOAD, ITER, FIX, DONE.
- IDLE: start=1 captures op/oper_A/oper_B and goes to LOAD; otherwise stays in IDLE.
- LOAD (1 cycle):
  - Signed ops (MULT, DIV): form magnitudes of both operands and record sign_res = A[W-1]^B[W-1] and sign_rem = A[W-1].
  - Unsigned ops: take operands as-is; both sign flags = 0.
  - Clear the 2W accumulator and load counter = WIDTH.
  - DIV/DIVU with oper_B==0: go directly to DONE, set div_zero, leave HI/LO unchanged. Otherwise go to ITER.
- ITER (WIDTH cycles, counter decrements to 0):
  - Multiply: if multiplier LSB=1, add multiplicand to upper half, then shift the {carry, acc} right by 1.
  - Divide: shift {rem, quo} left by 1; if rem >= divisor, subtract the divisor and set quo LSB.
  - Leaving ITER: when counter reaches 0, go to FIX.
- FIX (1 cycle), applying sign correction:
  - Multiply: negate the full 2W product if sign_res.
  - Divide: negate the quotient if sign_res; negate the remainder if sign_rem.
  - Register results into HI/LO at the FIX→DONE edge.
- DONE (1 cycle): done=1, busy=0, then unconditionally go to IDLE. A start in DONE is ignored.
- Latency, with start sampled in cycle N:
  - Normal op: LOAD at N+1, ITER N+2..N+W+1, FIX N+W+2, done in N+W+3 (N+35 for W=32).
  - Divide by zero: done in N+2.
- start while busy or done is ignored; inputs need not be held after the start cycle.
- HI/LO hold their value until the next completed operation or reset.
- Arithmetic:
  - All two's-complement, wrap-around, no exceptions.
  - The magnitude of -2^(W-1) is 2^(W-1) as an unsigned value.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Remainder sign follows the dividend; a zero remainder is never negated.

Optional Feature:
MULDIV_EARLY_EXIT_EN:
- Defined:
  - In multiply ITER, when the remaining unshifted multiplier bits are all zero, perform one final alignment and jump to FIX. The alignment is a bulk shift of the accumulator by the remaining counter value in a single cycle.
  - Multiply latency then becomes N+3+(index of highest set multiplier-magnitude bit)+2. A multiplier of 0 gives done at N+4.
  - Divide timing is unchanged.
  - Results are identical to the non-early-exit path.
- Undefined: fixed WIDTH iterations for all ops.

Test Plan:
1. MULT A=0xFFFFFFFF, B=0x00000002, start at N -> busy N+1..N+34, done at N+35, HI=0xFFFFFFFF, LO=0xFFFFFFFE.
2. MULTU A=0xFFFFFFFF, B=0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE at N+35.
3. DIV A=0xFFFFFFF9 (-7), B=0x00000002 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 7/2 -> LO=3, HI=1.
4. DIVU A=7, B=0 after a prior result HI=1, LO=3 -> done and div_zero at N+2, HI=1, LO=3 unchanged.
5. MULT started, reset asserted at N+10 -> at N+11 busy=0, HI=LO=0, state IDLE. A new start then completes normally.
6. Back-to-back: start held high continuously -> second op begins only from IDLE, done pulses W+4 cycles apart. Also DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
